// File: rtl/fsrc_polyphase.sv
// Fractional L/M rate converter: time-multiplexed polyphase FIR, one output per FETCH/MAC/ROUND/EMIT/WRAP pass.
// Output valid P+1 edges after the last needed input; out_ready low parks the block in EMIT and blocks input.
module fsrc_polyphase #(
  parameter int L      = 13,
  parameter int M      = 5,
  parameter int P      = 4,
  parameter int DIN_W  = 13,
  parameter int COEF_W = 18,
  parameter int SHIFT  = 16,
  parameter int DOUT_W = 13
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clk_enable,
  input  logic signed [DIN_W-1:0]    in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic signed [DOUT_W-1:0]   out_data,
  output logic                       out_sat,
  output logic                       out_valid,
  input  logic                       out_ready,
  input  logic                       coef_we,
  input  logic [$clog2(L*P)-1:0]     coef_addr,
  input  logic signed [COEF_W-1:0]   coef_data
);

  localparam int NT     = L * P;
  localparam int AW     = $clog2(NT);
  localparam int PW     = DIN_W + COEF_W;
  localparam int ACC_W  = DIN_W + COEF_W + $clog2(P) + 1;
  localparam int PH_W   = $clog2(L + M);
  localparam int K_W    = (P > 1) ? $clog2(P) : 1;
  localparam int NEED_W = $clog2(M / L + 2) + 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(P - 1);
  localparam logic signed [ACC_W-1:0] OMAX = {{(ACC_W-DOUT_W+1){1'b0}}, {(DOUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OMIN = {{(ACC_W-DOUT_W+1){1'b1}}, {(DOUT_W-1){1'b0}}};

  typedef enum logic [2:0] {ST_FETCH, ST_MAC, ST_ROUND, ST_EMIT, ST_WRAP} state_t;

  state_t                     r_state, w_state_nxt;
  logic [PH_W-1:0]            r_ph;
  logic [NEED_W-1:0]          r_need;
  logic [K_W-1:0]             r_k;
  logic signed [ACC_W-1:0]    r_acc;
  logic signed [DIN_W-1:0]    r_x [P];
  logic signed [COEF_W-1:0]   r_coef [NT];
  logic signed [DOUT_W-1:0]   r_out_data;
  logic                       r_out_sat;

  logic                       w_in_hs, w_out_hs;
  logic [AW-1:0]              w_idx;
  logic signed [COEF_W-1:0]   w_c;
  logic signed [DIN_W-1:0]    w_x;
  logic signed [PW-1:0]       w_c_ext, w_x_ext, w_prod;
  logic signed [ACC_W-1:0]    w_prod_ext;
  logic signed [ACC_W-1:0]    w_q, w_r;
  logic                       w_rbit, w_sat;
  logic signed [DOUT_W-1:0]   w_dout;

  assign out_data = r_out_data;
  assign out_sat  = r_out_sat;

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    w_in_hs     = 1'b0;
    w_out_hs    = 1'b0;
    case (r_state)
      ST_FETCH: begin
        in_ready = (r_need != '0) && !reset;
        w_in_hs  = in_ready && in_valid && clk_enable;
        if ((r_need == '0) || (w_in_hs && (r_need == NEED_W'(1))))
          w_state_nxt = ST_MAC;
      end
      ST_MAC:   if (r_k == K_LAST) w_state_nxt = ST_ROUND;
      ST_ROUND: w_state_nxt = ST_EMIT;
      ST_EMIT: begin
        out_valid = !reset;
        w_out_hs  = out_valid && out_ready && clk_enable;
        if (w_out_hs) w_state_nxt = ST_WRAP;
      end
      ST_WRAP:  if (r_ph < PH_W'(L)) w_state_nxt = ST_FETCH;
      default:  w_state_nxt = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)           r_state <= ST_FETCH;
    else if (clk_enable) r_state <= w_state_nxt;
  end

  // Tap k of the current phase lives at ph + k*L.
  assign w_idx      = AW'(r_ph) + AW'(r_k) * AW'(L);
  assign w_c        = r_coef[w_idx];
  assign w_x        = r_x[r_k];
  assign w_c_ext    = {{DIN_W{w_c[COEF_W-1]}}, w_c};
  assign w_x_ext    = {{COEF_W{w_x[DIN_W-1]}}, w_x};
  assign w_prod     = w_c_ext * w_x_ext;
  assign w_prod_ext = {{(ACC_W-PW){w_prod[PW-1]}}, w_prod};

  // Round half away from zero: a negative exact half must not be bumped toward zero.
  generate
    if (SHIFT == 0) begin : g_rnd_none
      assign w_rbit = 1'b0;
    end else if (SHIFT == 1) begin : g_rnd_one
      assign w_rbit = r_acc[0] & ~r_acc[ACC_W-1];
    end else begin : g_rnd_full
      assign w_rbit = r_acc[SHIFT-1] & (~r_acc[ACC_W-1] | (|r_acc[SHIFT-2:0]));
    end
  endgenerate

  assign w_q    = r_acc >>> SHIFT;
  assign w_r    = w_q + ACC_W'(w_rbit);
  assign w_sat  = (w_r > OMAX) || (w_r < OMIN);
  assign w_dout = (w_r > OMAX) ? OMAX[DOUT_W-1:0] :
                  (w_r < OMIN) ? OMIN[DOUT_W-1:0] : w_r[DOUT_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ph       <= '0;
      r_need     <= NEED_W'(1);
      r_k        <= '0;
      r_acc      <= '0;
      r_out_data <= '0;
      r_out_sat  <= 1'b0;
      for (int i = 0; i < P; i++)  r_x[i]    <= '0;
      for (int i = 0; i < NT; i++) r_coef[i] <= '0;
    end else if (clk_enable) begin
      if (coef_we) r_coef[coef_addr] <= coef_data;
      if (w_in_hs) begin
        r_x[0] <= in_data;
        for (int i = 1; i < P; i++) r_x[i] <= r_x[i-1];
        r_need <= r_need - NEED_W'(1);
      end
      case (r_state)
        ST_MAC: begin
          r_acc <= ((r_k == '0) ? '0 : r_acc) + w_prod_ext;
          r_k   <= (r_k == K_LAST) ? '0 : r_k + K_W'(1);
        end
        ST_ROUND: begin
          r_out_data <= w_dout;
          r_out_sat  <= w_sat;
        end
        ST_EMIT: if (w_out_hs) r_ph <= r_ph + PH_W'(M);
        ST_WRAP: begin
          if (r_ph >= PH_W'(L)) begin
            r_ph   <= r_ph - PH_W'(L);
            r_need <= r_need + NEED_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fsrc_polyphase.sv
// Randomized bench for fsrc_polyphase against a direct-form polyphase reference built from output index arithmetic.
module tb_fsrc_polyphase;
  localparam int L_P = 13, M_P = 5, P_P = 4, NT = L_P * P_P;
  localparam longint ONE = 65536, HALF = 32768, OMAX = 4095, OMIN = -4096;

  logic               clk = 1'b0;
  logic               reset, clk_enable, in_valid, in_ready;
  logic               out_sat, out_valid, out_ready, coef_we;
  logic signed [12:0] in_data, out_data;
  logic [5:0]         coef_addr;
  logic signed [17:0] coef_data;

  int n_total = 0, n_bad = 0;
  int h [NT];
  int src[$], xin[$];
  int j, in_idx;

  fsrc_polyphase #(.L(L_P), .M(M_P), .P(P_P), .DIN_W(13), .COEF_W(18), .SHIFT(16), .DOUT_W(13)) dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_sat(out_sat), .out_valid(out_valid), .out_ready(out_ready),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Output jj comes from phase (jj*M mod L) after floor(jj*M/L)+1 inputs; newest input is tap 0.
  function automatic void model(input int jj, output longint ed, output longint es);
    longint acc, r;
    int ph, cnt, idx;
    ph  = (jj * M_P) % L_P;
    cnt = (jj * M_P) / L_P + 1;
    acc = 0;
    for (int k = 0; k < P_P; k++) begin
      idx = cnt - 1 - k;
      if (idx >= 0 && idx < xin.size())
        acc += longint'(h[ph + k * L_P]) * longint'(xin[idx]);
    end
    if (acc >= 0) r = (acc + HALF) / ONE;
    else          r = -((-acc + HALF) / ONE);
    es = 0;
    if (r > OMAX)      begin r = OMAX; es = 1; end
    else if (r < OMIN) begin r = OMIN; es = 1; end
    ed = r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1; in_valid = 0; out_ready = 0; coef_we = 0; clk_enable = 1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sat", out_sat, 0);
    reset = 0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);
  endtask

  task automatic start();
    do_reset();
    xin.delete();
    j = 0;
    in_idx = 0;
  endtask

  task automatic load_coefs();
    for (int a = 0; a < NT; a++) begin
      @(negedge clk);
      coef_we = 1; coef_addr = 6'(a); coef_data = 18'(h[a]);
    end
    @(negedge clk);
    coef_we = 0;
  endtask

  task automatic run(input string nm, input int n_out, input int vp, input int rp, input int ep, input bit hold);
    int cyc;
    bit held;
    longint ed, es;
    cyc = 0;
    held = 0;
    while (j < n_out && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (hold && !held && out_valid) begin
        held = 1;
        model(0, ed, es);
        for (int c = 0; c < 20; c++) begin
          out_ready = 0; clk_enable = 1;
          in_valid = (in_idx < src.size());
          in_data = (in_idx < src.size()) ? 13'(src[in_idx]) : '0;
          #1;
          chk("hold_data", out_data, ed);
          chk("hold_in_ready", in_ready, 0);
          chk("hold_valid", out_valid, 1);
          @(negedge clk);
        end
      end
      in_valid   = (in_idx < src.size()) && ($urandom_range(99) < vp);
      in_data    = (in_idx < src.size()) ? 13'(src[in_idx]) : '0;
      out_ready  = ($urandom_range(99) < rp);
      clk_enable = ($urandom_range(99) < ep);
      #1;
      chk("excl", in_ready && out_valid, 0);
      if (in_valid && in_ready && clk_enable) begin
        xin.push_back(src[in_idx]);
        in_idx++;
      end
      if (out_valid && out_ready && clk_enable) begin
        model(j, ed, es);
        chk({nm, "_consumed"}, xin.size(), (j * M_P) / L_P + 1);
        chk({nm, "_data"}, out_data, ed);
        chk({nm, "_sat"}, out_sat, es);
        j++;
      end
    end
    if (j < n_out) chk({nm, "_timeout"}, j, n_out);
    @(negedge clk);
    in_valid = 0; out_ready = 0; clk_enable = 1;
  endtask

  task automatic set_k0(input int v);
    for (int a = 0; a < NT; a++) h[a] = (a < L_P) ? v : 0;
  endtask

  initial begin
    bit got;
    reset = 1; clk_enable = 1; in_valid = 0; in_data = '0;
    out_ready = 0; coef_we = 0; coef_addr = '0; coef_data = '0;

    // Zero-order hold, plus a write with clk_enable low that must be ignored.
    start();
    set_k0(65536);
    load_coefs();
    @(negedge clk);
    clk_enable = 0; coef_we = 1; coef_addr = 6'd0; coef_data = 18'(h[0] + 12345);
    @(negedge clk);
    coef_we = 0; clk_enable = 1;
    src.delete();
    for (int i = 1; i <= 40; i++) src.push_back(i);
    run("zoh", 30, 100, 100, 100, 0);

    start();
    for (int a = 0; a < NT; a++) h[a] = (a + 1) * 1500;
    load_coefs();
    src.delete();
    src.push_back(512);
    for (int i = 0; i < 40; i++) src.push_back(0);
    run("imp", 26, 100, 100, 100, 0);

    start();
    set_k0(32768);
    load_coefs();
    src = '{3, -3, 1, -1, 5, -5, 2, -2};
    run("round", 19, 100, 100, 100, 0);

    start();
    set_k0(131071);
    load_coefs();
    src = '{4095, -4096, 100, 2047, 2048, -2048, -2049, 0};
    run("sat", 19, 100, 100, 100, 0);

    start();
    set_k0(65536);
    load_coefs();
    src.delete();
    for (int i = 0; i < 20; i++) src.push_back(int'($urandom_range(0, 8191)) - 4096);
    run("hold", 10, 100, 100, 100, 1);

    for (int t = 0; t < 2; t++) begin
      start();
      for (int a = 0; a < NT; a++)
        h[a] = (t == 0) ? int'($urandom_range(0, 80000)) - 40000 : int'($urandom_range(0, 262143)) - 131072;
      load_coefs();
      src.delete();
      for (int i = 0; i < 80; i++) src.push_back(int'($urandom_range(0, 8191)) - 4096);
      run((t == 0) ? "rnd_a" : "rnd_b", 60, 70, 60, 60, 0);
    end

    // Reset in the middle of MAC; the next output must see only post-reset input.
    start();
    set_k0(65536);
    load_coefs();
    src = '{100, 200, 300};
    run("pre_rst", 3, 100, 100, 100, 0);
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      in_valid = 1; in_data = 13'sd77; out_ready = 0; clk_enable = 1;
      #1;
      if (in_ready) got = 1;
    end
    chk("mid_wait_ready", got, 1);
    @(negedge clk);
    in_valid = 0;
    chk("mid_in_mac", in_ready, 0);
    do_reset();
    xin.delete(); j = 0; in_idx = 0;
    load_coefs();
    src = '{55, -66, 77, -88};
    run("post_rst", 4, 80, 80, 80, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
